// File: rtl/ariane_axi.sv
// Minimal AXI4 channel and bundle types shared by the cache subsystem's memory port.
package ariane_axi;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } aw_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

// File: rtl/std_cache_pkg.sv
// Shared constants and types for the standard cache subsystem's memory-port logic.
package std_cache_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int unsigned DEF_MAX_RD_TXNS = 8;
  localparam int unsigned DEF_MAX_WR_TXNS = 4;

  typedef enum logic [1:0] {
    WD_IDLE,
    WD_COUNT,
    WD_TIMEOUT
  } wd_state_e;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/txn_updown_cnt.sv
// Saturating up/down occupancy counter (0..Max); simultaneous inc and dec cancel.
module txn_updown_cnt #(
  parameter  int unsigned Max   = 4,
  localparam int unsigned Width = $clog2(Max + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [Width-1:0] cnt_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && !dec_i && !full_o) begin
      cnt_q <= cnt_q + Width'(1);
    end else if (dec_i && !inc_i && !empty_o) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign cnt_o   = cnt_q;
  assign full_o  = (cnt_q == Width'(Max));
  assign empty_o = (cnt_q == '0);

  // A lone decrement while empty means the far side broke the AXI protocol.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !clr_i) begin
      assert (!(dec_i && !inc_i && empty_o));
    end
  end

endmodule

// File: rtl/axi_txn_limiter.sv
// Outstanding-transaction limiter / W-credit gate on the cache memory port.
// Optional watchdog enabled by defining AXI_TXN_WATCHDOG_EN.
module axi_txn_limiter
  import std_cache_pkg::*;
#(
  parameter int unsigned MaxRdTxns     = DEF_MAX_RD_TXNS,
  parameter int unsigned MaxWrTxns     = DEF_MAX_WR_TXNS,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              block_i,
  input  ariane_axi::req_t  slv_req_i,
  output ariane_axi::resp_t slv_resp_o,
  output ariane_axi::req_t  mst_req_o,
  input  ariane_axi::resp_t mst_resp_i,
  output logic              idle_o,
  output logic [15:0]       err_cnt_o,
  output logic              timeout_o
);

  localparam int unsigned RdW = $clog2(MaxRdTxns + 1);
  localparam int unsigned WrW = $clog2(MaxWrTxns + 1);

  if (MaxRdTxns < 1 || MaxRdTxns > 255 || MaxWrTxns < 1 || MaxWrTxns > 255 ||
      TimeoutCycles < 1) begin : g_bad_cfg
    $error("axi_txn_limiter: parameter out of range");
  end

  logic           rd_full, rd_empty, wr_full, wr_empty, wc_empty;
  logic           unused_wc_full;
  logic [RdW-1:0] unused_rd_cnt;
  logic [WrW-1:0] unused_wr_cnt, unused_wc_cnt;
  logic           ar_open, aw_open, w_open;
  logic           ar_hs, aw_hs, w_last_hs, r_last_hs, b_hs;
  logic           r_err, b_err;
  logic [16:0]    err_sum;
  logic [15:0]    err_q;
  logic           idle_q;

  // Gates depend only on registered counts, so no ready->valid loop is formed.
  assign ar_open = ~block_i & ~rd_full;
  assign aw_open = ~block_i & ~wr_full;
  assign w_open  = ~wc_empty;

  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.ar_valid = slv_req_i.ar_valid & ar_open;
    mst_req_o.aw_valid = slv_req_i.aw_valid & aw_open;
    mst_req_o.w_valid  = slv_req_i.w_valid & w_open;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_open;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_open;
    slv_resp_o.w_ready  = mst_resp_i.w_ready & w_open;
  end

  assign ar_hs     = mst_req_o.ar_valid & mst_resp_i.ar_ready;
  assign aw_hs     = mst_req_o.aw_valid & mst_resp_i.aw_ready;
  assign w_last_hs = mst_req_o.w_valid & mst_resp_i.w_ready & slv_req_i.w.last;
  assign r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
  assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;

  txn_updown_cnt #(.Max(MaxRdTxns)) i_rd_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .inc_i   (ar_hs),
    .dec_i   (r_last_hs),
    .cnt_o   (unused_rd_cnt),
    .full_o  (rd_full),
    .empty_o (rd_empty)
  );

  txn_updown_cnt #(.Max(MaxWrTxns)) i_wr_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .inc_i   (aw_hs),
    .dec_i   (b_hs),
    .cnt_o   (unused_wr_cnt),
    .full_o  (wr_full),
    .empty_o (wr_empty)
  );

  txn_updown_cnt #(.Max(MaxWrTxns)) i_w_cred (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .inc_i   (aw_hs),
    .dec_i   (w_last_hs),
    .cnt_o   (unused_wc_cnt),
    .full_o  (unused_wc_full),
    .empty_o (wc_empty)
  );

  assign r_err   = r_last_hs & resp_is_err(mst_resp_i.r.resp);
  assign b_err   = b_hs & resp_is_err(mst_resp_i.b.resp);
  assign err_sum = {1'b0, err_q} + 17'(r_err) + 17'(b_err);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q  <= '0;
      idle_q <= 1'b1;
    end else if (clr_i) begin
      err_q  <= '0;
      idle_q <= 1'b1;
    end else begin
      err_q  <= err_sum[16] ? '1 : err_sum[15:0];
      idle_q <= rd_empty & wr_empty & wc_empty;
    end
  end

  assign err_cnt_o = err_q;
  assign idle_o    = idle_q;

`ifdef AXI_TXN_WATCHDOG_EN
  localparam logic [31:0] WdLast = 32'(TimeoutCycles - 1);

  wd_state_e   wd_q, wd_d;
  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic        busy, rb_hs;

  assign busy  = ~(rd_empty & wr_empty & wc_empty);
  assign rb_hs = (mst_resp_i.r_valid & slv_req_i.r_ready) | b_hs;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q     <= WD_IDLE;
      wd_cnt_q <= '0;
    end else if (clr_i) begin
      wd_q     <= WD_IDLE;
      wd_cnt_q <= '0;
    end else begin
      wd_q     <= wd_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  always_comb begin
    wd_d     = wd_q;
    wd_cnt_d = wd_cnt_q;
    unique case (wd_q)
      WD_IDLE: begin
        if (busy) begin
          wd_d     = WD_COUNT;
          wd_cnt_d = '0;
        end
      end
      WD_COUNT: begin
        if (!busy) begin
          wd_d = WD_IDLE;
        end else if (wd_cnt_q == WdLast) begin
          wd_d = WD_TIMEOUT;
        end else if (rb_hs) begin
          wd_cnt_d = '0;
        end else begin
          wd_cnt_d = wd_cnt_q + 32'd1;
        end
      end
      WD_TIMEOUT: wd_d = WD_TIMEOUT;
      default:    wd_d = WD_IDLE;
    endcase
  end

  assign timeout_o = (wd_q == WD_TIMEOUT);
`else
  assign timeout_o = 1'b0;
`endif

endmodule
